// File: rtl/contador_bcd.sv
// Two-digit BCD up/down counter with guarded synchronous load and terminal-count flag.
// Optional down counting is enabled by defining CONTADOR_BCD_DOWN_EN.
module contador_bcd #(
  parameter int unsigned LIMITE = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       ld,
  input  logic [7:0] d_in,
  input  logic       dn,
  output logic       H,
  output logic       G,
  output logic       F,
  output logic       E,
  output logic [3:0] dez,
  output logic       tc,
  output logic       ld_err
);

  localparam int unsigned DW = 4;
  localparam int unsigned VW = 8;
  localparam logic [DW-1:0] LIM_T = DW'(LIMITE / 10);
  localparam logic [DW-1:0] LIM_U = DW'(LIMITE % 10);
  localparam logic [VW-1:0] LIM_V = VW'(LIMITE);

  typedef struct packed {
    logic [DW-1:0] tens;
    logic [DW-1:0] units;
  } bcd_t;

  bcd_t state_q, state_d;
  bcd_t load_s, inc_s;
  logic err_q, err_d;
  logic at_lim;
  logic ld_ok;
  logic [VW-1:0] load_val;

  assign load_s   = bcd_t'(d_in);
  assign at_lim   = (state_q.tens == LIM_T) && (state_q.units == LIM_U);
  // Decimal value only meaningful when both nibbles are valid digits.
  assign load_val = (VW'(load_s.tens) * VW'(10)) + VW'(load_s.units);
  assign ld_ok    = (load_s.tens <= DW'(9)) && (load_s.units <= DW'(9)) &&
                    (load_val <= LIM_V);

  // Up-count successor with decimal carry and wrap at LIMITE.
  always_comb begin
    inc_s = state_q;
    if (at_lim) begin
      inc_s = '0;
    end else if (state_q.units == DW'(9)) begin
      inc_s.units = '0;
      inc_s.tens  = state_q.tens + DW'(1);
    end else begin
      inc_s.units = state_q.units + DW'(1);
    end
  end

`ifdef CONTADOR_BCD_DOWN_EN
  bcd_t dec_s;
  logic at_zero;

  assign at_zero = (state_q == '0);

  // Down-count successor with decimal borrow and wrap to LIMITE.
  always_comb begin
    dec_s = state_q;
    if (at_zero) begin
      dec_s.tens  = LIM_T;
      dec_s.units = LIM_U;
    end else if (state_q.units == '0) begin
      dec_s.units = DW'(9);
      dec_s.tens  = state_q.tens - DW'(1);
    end else begin
      dec_s.units = state_q.units - DW'(1);
    end
  end

  assign tc = en & ~ld & ((~dn & at_lim) | (dn & at_zero));
`else
  logic unused_dn;

  assign unused_dn = dn;
  assign tc        = en & ~ld & at_lim;
`endif

  // Next state: load has priority over count; a bad load holds and flags.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    if (ld) begin
      if (ld_ok) begin
        state_d = load_s;
      end else begin
        err_d = 1'b1;
      end
    end else if (en) begin
`ifdef CONTADOR_BCD_DOWN_EN
      state_d = dn ? dec_s : inc_s;
`else
      state_d = inc_s;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign {H, G, F, E} = state_q.units;
  assign dez          = state_q.tens;
  assign ld_err       = err_q;

endmodule

// File: tb/tb_contador_bcd.sv
// Scoreboard bench for contador_bcd: LIMITE=99 and LIMITE=59 instances on shared stimulus.
module tb_contador_bcd;

  typedef struct packed {
    logic [3:0] dez;
    logic [3:0] uni;
    logic       err;
    logic       tc;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       ld = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic       dn = 1'b0;

  logic       a_h, a_g, a_f, a_e, a_tc, a_err;
  logic [3:0] a_dez;
  logic       b_h, b_g, b_f, b_e, b_tc, b_err;
  logic [3:0] b_dez;

  int checks = 0;
  int errors = 0;
  int va = 0;
  int vb = 0;

  obs_t exp_a[$], act_a[$], exp_b[$], act_b[$];

  contador_bcd #(.LIMITE(99)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .ld(ld), .d_in(d_in), .dn(dn),
    .H(a_h), .G(a_g), .F(a_f), .E(a_e), .dez(a_dez), .tc(a_tc), .ld_err(a_err)
  );

  contador_bcd #(.LIMITE(59)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .ld(ld), .d_in(d_in), .dn(dn),
    .H(b_h), .G(b_g), .F(b_f), .E(b_e), .dez(b_dez), .tc(b_tc), .ld_err(b_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int model_next(input int v, input int lim, input bit e, input bit l,
                                    input logic [7:0] di, input bit d, output bit err);
    int t = int'(di[7:4]);
    int u = int'(di[3:0]);
    err = 1'b0;
    if (l) begin
      if (t <= 9 && u <= 9 && (t * 10 + u) <= lim) return t * 10 + u;
      err = 1'b1;
      return v;
    end
    if (e) begin
      if (d) return (v == 0) ? lim : v - 1;
      return (v == lim) ? 0 : v + 1;
    end
    return v;
  endfunction

  function automatic bit model_tc(input int v, input int lim, input bit e, input bit l, input bit d);
    return e && !l && (d ? (v == 0) : (v == lim));
  endfunction

  // Drives one cycle, pushes model expectations and the sampled DUT outputs.
  task automatic cycle(input bit e, input bit l, input logic [7:0] di, input bit d);
    obs_t ea, aa, eb, ab;
    bit d_eff;
    bit er;
`ifdef CONTADOR_BCD_DOWN_EN
    d_eff = d;
`else
    d_eff = 1'b0;
`endif
    @(negedge clk);
    en = e; ld = l; d_in = di; dn = d;
    #1;
    ea.tc = model_tc(va, 99, e, l, d_eff);
    eb.tc = model_tc(vb, 59, e, l, d_eff);
    aa.tc = a_tc;
    ab.tc = b_tc;
    va = model_next(va, 99, e, l, di, d_eff, er);
    ea.err = er;
    vb = model_next(vb, 59, e, l, di, d_eff, er);
    eb.err = er;
    ea.dez = 4'(va / 10); ea.uni = 4'(va % 10);
    eb.dez = 4'(vb / 10); eb.uni = 4'(vb % 10);
    @(posedge clk);
    #1;
    aa.dez = a_dez; aa.uni = {a_h, a_g, a_f, a_e}; aa.err = a_err;
    ab.dez = b_dez; ab.uni = {b_h, b_g, b_f, b_e}; ab.err = b_err;
    exp_a.push_back(ea); act_a.push_back(aa);
    exp_b.push_back(eb); act_b.push_back(ab);
  endtask

  task automatic test_reset;
    obs_t e, a;
    en = 1'b0; ld = 1'b0; rst_n = 1'b0;
    #3;
    e = '0;
    a = {a_dez, a_h, a_g, a_f, a_e, a_err, a_tc};
    checks++;
    if (a !== e) begin errors++; $display("FAIL reset_a got %h want %h", a, e); end
    a = {b_dez, b_h, b_g, b_f, b_e, b_err, b_tc};
    checks++;
    if (a !== e) begin errors++; $display("FAIL reset_b got %h want %h", a, e); end
    @(negedge clk);
    rst_n = 1'b1;
    va = 0; vb = 0;
  endtask

  task automatic test_count_up;
    obs_t e, a;
    int n = 0;
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
    while (exp_a.size() > 0) begin
      n++;
      e = exp_a.pop_front(); a = act_a.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL count_up_a step %0d got %h want %h", n, a, e); end
      e = exp_b.pop_front(); a = act_b.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL count_up_b step %0d got %h want %h", n, a, e); end
    end
    checks++;
    if ({a_dez, a_h, a_g, a_f, a_e} !== 8'h12) begin
      errors++; $display("FAIL count_up_final got %h want 12", {a_dez, a_h, a_g, a_f, a_e});
    end
  endtask

  task automatic test_wrap;
    obs_t e, a;
    int n = 0;
    cycle(1'b0, 1'b1, 8'h98, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h58, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h60, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    while (exp_a.size() > 0) begin
      n++;
      e = exp_a.pop_front(); a = act_a.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL wrap_a step %0d got %h want %h", n, a, e); end
      e = exp_b.pop_front(); a = act_b.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL wrap_b step %0d got %h want %h", n, a, e); end
    end
  endtask

  task automatic test_bad_load;
    obs_t e, a;
    int n = 0;
    cycle(1'b0, 1'b1, 8'h3A, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 8'hA1, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    while (exp_a.size() > 0) begin
      n++;
      e = exp_a.pop_front(); a = act_a.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL bad_load_a step %0d got %h want %h", n, a, e); end
      e = exp_b.pop_front(); a = act_b.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL bad_load_b step %0d got %h want %h", n, a, e); end
    end
  endtask

  task automatic test_down;
    obs_t e, a;
    int n = 0;
    cycle(1'b0, 1'b1, 8'h10, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b1, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    while (exp_a.size() > 0) begin
      n++;
      e = exp_a.pop_front(); a = act_a.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL down_a step %0d got %h want %h", n, a, e); end
      e = exp_b.pop_front(); a = act_b.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL down_b step %0d got %h want %h", n, a, e); end
    end
  endtask

  task automatic test_reset_mid;
    obs_t e, a;
    int n = 0;
    cycle(1'b0, 1'b1, 8'h47, 1'b0);
    @(negedge clk);
    ld = 1'b1; en = 1'b0; d_in = 8'h12;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_dez, a_h, a_g, a_f, a_e, a_err} !== 9'h0) begin
      errors++; $display("FAIL reset_mid_a got %h want 000", {a_dez, a_h, a_g, a_f, a_e, a_err});
    end
    checks++;
    if ({b_dez, b_h, b_g, b_f, b_e, b_err} !== 9'h0) begin
      errors++; $display("FAIL reset_mid_b got %h want 000", {b_dez, b_h, b_g, b_f, b_e, b_err});
    end
    @(posedge clk);
    #1;
    ld = 1'b0;
    rst_n = 1'b1;
    va = 0; vb = 0;
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 8'h25, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    while (exp_a.size() > 0) begin
      n++;
      e = exp_a.pop_front(); a = act_a.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL reset_mid_seq_a step %0d got %h want %h", n, a, e); end
      e = exp_b.pop_front(); a = act_b.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL reset_mid_seq_b step %0d got %h want %h", n, a, e); end
    end
  endtask

  task automatic test_back_to_back;
    obs_t e, a;
    int n = 0;
    logic [7:0] di;
    for (int i = 0; i < 60; i++) begin
      di = {4'($urandom_range(0, 10)), 4'($urandom_range(0, 10))};
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0), di,
            1'($urandom_range(0, 1)));
    end
    while (exp_a.size() > 0) begin
      n++;
      e = exp_a.pop_front(); a = act_a.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL b2b_a step %0d got %h want %h", n, a, e); end
      e = exp_b.pop_front(); a = act_b.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL b2b_b step %0d got %h want %h", n, a, e); end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_bad_load();
    test_down();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
